// File: rtl/branch_issue_queue_if.sv
// Dispatch, wakeup, flush and issue signal bundle for the branch issue queue.
interface branch_issue_queue_if #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PAYLOAD_W = 128
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic                 flush_i;
    logic                 dispatch_valid_i;
    logic                 dispatch_ready_o;
    logic [PAYLOAD_W-1:0] dispatch_payload_i;
    logic [5:0]           dispatch_rs1_i;
    logic [5:0]           dispatch_rs2_i;
    logic                 dispatch_rs1_rdy_i;
    logic                 dispatch_rs2_rdy_i;
    logic [5:0]           dispatch_rob_i;
    logic [5:0]           dispatch_dest_i;
    logic                 wkp0_valid_i;
    logic                 wkp1_valid_i;
    logic [5:0]           wkp0_tag_i;
    logic [5:0]           wkp1_tag_i;
    logic                 issue_valid_o;
    logic [PAYLOAD_W-1:0] issue_payload_o;
    logic [5:0]           issue_rs1_o;
    logic [5:0]           issue_rs2_o;
    logic [5:0]           issue_rob_o;
    logic [5:0]           issue_dest_o;
    logic [OCC_W-1:0]     occupancy_o;

    modport master (
        output flush_i, dispatch_valid_i, dispatch_payload_i, dispatch_rs1_i, dispatch_rs2_i,
               dispatch_rs1_rdy_i, dispatch_rs2_rdy_i, dispatch_rob_i, dispatch_dest_i,
               wkp0_valid_i, wkp1_valid_i, wkp0_tag_i, wkp1_tag_i,
        input  dispatch_ready_o, issue_valid_o, issue_payload_o, issue_rs1_o, issue_rs2_o,
               issue_rob_o, issue_dest_o, occupancy_o
    );

    modport slave (
        input  flush_i, dispatch_valid_i, dispatch_payload_i, dispatch_rs1_i, dispatch_rs2_i,
               dispatch_rs1_rdy_i, dispatch_rs2_rdy_i, dispatch_rob_i, dispatch_dest_i,
               wkp0_valid_i, wkp1_valid_i, wkp0_tag_i, wkp1_tag_i,
        output dispatch_ready_o, issue_valid_o, issue_payload_o, issue_rs1_o, issue_rs2_o,
               issue_rob_o, issue_dest_o, occupancy_o
    );
endinterface

// File: rtl/branch_issue_queue.sv
// Age-ordered collapsing issue queue feeding the single branch execution pipe.
// Entry 0 is oldest; the oldest entry with both sources ready issues each cycle.
module branch_issue_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PAYLOAD_W = 128
) (
    input  logic               cpu_clock_i,
    input  logic               cpu_reset_i,
    branch_issue_queue_if.slave bus
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                 valid;
        logic [PAYLOAD_W-1:0] payload;
        logic [5:0]           rs1;
        logic [5:0]           rs2;
        logic                 rdy1;
        logic                 rdy2;
        logic [5:0]           rob;
        logic [5:0]           dest;
    } entry_t;

    entry_t               q     [DEPTH];
    entry_t               q_n   [DEPTH];
    entry_t               woke  [DEPTH];
    entry_t               new_entry;
    logic [OCC_W-1:0]     occ_q;
    logic [OCC_W-1:0]     occ_n;
    logic [IDX_W-1:0]     sel_idx;
    logic                 any_cand;
    logic                 issue_c;
    logic                 accept_c;
    logic                 ready_c;
    logic                 iss_valid_q;
    logic [PAYLOAD_W-1:0] iss_payload_q;
    logic [5:0]           iss_rs1_q;
    logic [5:0]           iss_rs2_q;
    logic [5:0]           iss_rob_q;
    logic [5:0]           iss_dest_q;

    function automatic logic wake_hit(input logic [5:0] tag,
                                      input logic v0, input logic [5:0] t0,
                                      input logic v1, input logic [5:0] t1);
        return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    // Full-ness is taken from registered occupancy only, so an issue never frees a slot same-cycle
    assign ready_c  = (occ_q < OCC_W'(DEPTH));
    assign accept_c = bus.dispatch_valid_i && ready_c && !bus.flush_i;
    assign issue_c  = any_cand && !bus.flush_i;

    // Oldest-first select over registered ready bits
    always_comb begin
        sel_idx  = '0;
        any_cand = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (q[i].valid && q[i].rdy1 && q[i].rdy2) begin
                sel_idx  = IDX_W'(i);
                any_cand = 1'b1;
            end
        end
    end

    // Wakeup, collapse and dispatch write
    always_comb begin
        int wr_pos;
        int occ_sum;
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.payload = bus.dispatch_payload_i;
        new_entry.rs1     = bus.dispatch_rs1_i;
        new_entry.rs2     = bus.dispatch_rs2_i;
        new_entry.rob     = bus.dispatch_rob_i;
        new_entry.dest    = bus.dispatch_dest_i;
        new_entry.rdy1    = bus.dispatch_rs1_rdy_i || (bus.dispatch_rs1_i == 6'd0) ||
                            wake_hit(bus.dispatch_rs1_i, bus.wkp0_valid_i, bus.wkp0_tag_i,
                                     bus.wkp1_valid_i, bus.wkp1_tag_i);
        new_entry.rdy2    = bus.dispatch_rs2_rdy_i || (bus.dispatch_rs2_i == 6'd0) ||
                            wake_hit(bus.dispatch_rs2_i, bus.wkp0_valid_i, bus.wkp0_tag_i,
                                     bus.wkp1_valid_i, bus.wkp1_tag_i);

        wr_pos = int'(occ_q) - (issue_c ? 1 : 0);

        for (int i = 0; i < int'(DEPTH); i++) begin
            woke[i]      = q[i];
            woke[i].rdy1 = q[i].rdy1 || wake_hit(q[i].rs1, bus.wkp0_valid_i, bus.wkp0_tag_i,
                                                  bus.wkp1_valid_i, bus.wkp1_tag_i);
            woke[i].rdy2 = q[i].rdy2 || wake_hit(q[i].rs2, bus.wkp0_valid_i, bus.wkp0_tag_i,
                                                  bus.wkp1_valid_i, bus.wkp1_tag_i);
        end

        for (int i = 0; i < int'(DEPTH); i++) begin
            int j;
            j      = (i < int'(DEPTH) - 1) ? i + 1 : i;
            q_n[i] = woke[i];
            if (issue_c && (i >= int'(sel_idx))) begin
                if (i == int'(DEPTH) - 1) q_n[i] = '0;
                else                      q_n[i] = woke[j];
            end
            if (accept_c && (wr_pos == i)) q_n[i] = new_entry;
            if (bus.flush_i)               q_n[i] = '0;
        end

        occ_sum = int'(occ_q) + (accept_c ? 1 : 0) - (issue_c ? 1 : 0);
        if (occ_sum < 0)               occ_sum = 0;
        if (occ_sum > int'(DEPTH))     occ_sum = int'(DEPTH);
        occ_n = OCC_W'(occ_sum);
        if (bus.flush_i) occ_n = '0;
    end

    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) q[i] <= '0;
            occ_q         <= '0;
            iss_valid_q   <= 1'b0;
            iss_payload_q <= '0;
            iss_rs1_q     <= '0;
            iss_rs2_q     <= '0;
            iss_rob_q     <= '0;
            iss_dest_q    <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) q[i] <= q_n[i];
            occ_q       <= occ_n;
            iss_valid_q <= issue_c;
            if (issue_c) begin
                iss_payload_q <= q[sel_idx].payload;
                iss_rs1_q     <= q[sel_idx].rs1;
                iss_rs2_q     <= q[sel_idx].rs2;
                iss_rob_q     <= q[sel_idx].rob;
                iss_dest_q    <= q[sel_idx].dest;
            end
        end
    end

    assign bus.dispatch_ready_o = ready_c;
    assign bus.occupancy_o      = occ_q;
    assign bus.issue_valid_o    = iss_valid_q;
    assign bus.issue_payload_o  = iss_payload_q;
    assign bus.issue_rs1_o      = iss_rs1_q;
    assign bus.issue_rs2_o      = iss_rs2_q;
    assign bus.issue_rob_o      = iss_rob_q;
    assign bus.issue_dest_o     = iss_dest_q;
endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed bench for branch_issue_queue: latency, ordering, bypass, full, flush and reset.
module tb_branch_issue_queue;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned PAYLOAD_W = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    branch_issue_queue_if #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) bus ();

    branch_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
        .cpu_clock_i (clk),
        .cpu_reset_i (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pay_of(input logic [5:0] rob);
        logic [127:0] p;
        p = {64'hA5A5_0000_0000_0000, 58'd0, rob};
        return p;
    endfunction

    // Drive a dispatch request with rs2 fixed to the always-ready tag 0
    task automatic disp(input logic v, input logic [5:0] rs1, input logic rs1_rdy, input logic [5:0] rob);
        bus.dispatch_valid_i   = v;
        bus.dispatch_rs1_i     = rs1;
        bus.dispatch_rs1_rdy_i = rs1_rdy;
        bus.dispatch_rs2_i     = 6'd0;
        bus.dispatch_rs2_rdy_i = 1'b0;
        bus.dispatch_rob_i     = rob;
        bus.dispatch_dest_i    = rob + 6'd1;
        bus.dispatch_payload_i = pay_of(rob);
    endtask

    task automatic wake(input logic v0, input logic [5:0] t0, input logic v1, input logic [5:0] t1);
        bus.wkp0_valid_i = v0;
        bus.wkp0_tag_i   = t0;
        bus.wkp1_valid_i = v1;
        bus.wkp1_tag_i   = t1;
    endtask

    task automatic idle();
        disp(1'b0, 6'd0, 1'b0, 6'd0);
        wake(1'b0, 6'd0, 1'b0, 6'd0);
        bus.flush_i = 1'b0;
    endtask

    initial begin
        idle();
        #2;
        chk("reset_occ",   64'(bus.occupancy_o), 0);
        chk("reset_iv",    64'(bus.issue_valid_o), 0);
        chk("reset_ready", 64'(bus.dispatch_ready_o), 1);
        chk("reset_rob",   64'(bus.issue_rob_o), 0);
        #10 rst = 1'b0;
        tick();

        // Single ready op: issue two edges after dispatch
        disp(1'b1, 6'd0, 1'b0, 6'd5);
        tick();
        idle();
        chk("t1_occ1", 64'(bus.occupancy_o), 1);
        chk("t1_iv0",  64'(bus.issue_valid_o), 0);
        tick();
        chk("t1_iv",   64'(bus.issue_valid_o), 1);
        chk("t1_rob",  64'(bus.issue_rob_o), 5);
        chk("t1_dest", 64'(bus.issue_dest_o), 6);
        chk("t1_pay",  bus.issue_payload_o, pay_of(6'd5));
        chk("t1_occ0", 64'(bus.occupancy_o), 0);
        tick();
        chk("t1_iv_drop", 64'(bus.issue_valid_o), 0);

        // Oldest-ready ordering around a waiting older op
        disp(1'b1, 6'd12, 1'b0, 6'd1); tick();
        disp(1'b1, 6'd7,  1'b1, 6'd2); tick();
        disp(1'b1, 6'd8,  1'b1, 6'd3); tick();
        idle();
        chk("t2_iv_a",  64'(bus.issue_valid_o), 1);
        chk("t2_rob_a", 64'(bus.issue_rob_o), 2);
        chk("t2_rs1_a", 64'(bus.issue_rs1_o), 7);
        chk("t2_occ_a", 64'(bus.occupancy_o), 2);
        tick();
        chk("t2_rob_b", 64'(bus.issue_rob_o), 3);
        chk("t2_occ_b", 64'(bus.occupancy_o), 1);
        tick();
        chk("t2_iv_c",  64'(bus.issue_valid_o), 0);
        wake(1'b0, 6'd0, 1'b1, 6'd12);
        tick();
        idle();
        chk("t2_iv_w",  64'(bus.issue_valid_o), 0);
        chk("t2_rob_hold", 64'(bus.issue_rob_o), 3);
        tick();
        chk("t2_iv_d",  64'(bus.issue_valid_o), 1);
        chk("t2_rob_d", 64'(bus.issue_rob_o), 1);
        chk("t2_occ_d", 64'(bus.occupancy_o), 0);
        tick();

        // Wakeup bypass in the dispatch cycle
        disp(1'b1, 6'd20, 1'b0, 6'd7);
        wake(1'b1, 6'd20, 1'b0, 6'd0);
        tick();
        idle();
        chk("t3_iv0", 64'(bus.issue_valid_o), 0);
        tick();
        chk("t3_iv",  64'(bus.issue_valid_o), 1);
        chk("t3_rob", 64'(bus.issue_rob_o), 7);
        tick();

        // Fill the queue with waiting ops, each on its own tag
        for (int i = 0; i < 8; i++) begin
            disp(1'b1, 6'(30 + i), 1'b0, 6'(10 + i));
            tick();
        end
        idle();
        chk("t4_occ_full", 64'(bus.occupancy_o), 8);
        chk("t4_ready0",   64'(bus.dispatch_ready_o), 0);
        disp(1'b1, 6'd0, 1'b1, 6'd40);
        tick();
        idle();
        chk("t4_drop_occ", 64'(bus.occupancy_o), 8);
        chk("t4_drop_iv",  64'(bus.issue_valid_o), 0);
        wake(1'b1, 6'd33, 1'b0, 6'd0);
        tick();
        idle();
        chk("t4_ready_w", 64'(bus.dispatch_ready_o), 0);
        // Issue cycle while full: this dispatch must still be refused
        disp(1'b1, 6'd0, 1'b1, 6'd41);
        tick();
        idle();
        chk("t4_iv",     64'(bus.issue_valid_o), 1);
        chk("t4_rob",    64'(bus.issue_rob_o), 13);
        chk("t4_occ7",   64'(bus.occupancy_o), 7);
        chk("t4_ready1", 64'(bus.dispatch_ready_o), 1);
        tick();
        chk("t4_no_ghost", 64'(bus.issue_valid_o), 0);
        bus.flush_i = 1'b1;
        tick();
        idle();
        chk("t4_flush_occ", 64'(bus.occupancy_o), 0);

        // Dispatch and issue together at occupancy 1
        disp(1'b1, 6'd0, 1'b1, 6'd50); tick();
        disp(1'b1, 6'd44, 1'b0, 6'd51); tick();
        idle();
        chk("t5_iv",  64'(bus.issue_valid_o), 1);
        chk("t5_rob", 64'(bus.issue_rob_o), 50);
        chk("t5_occ", 64'(bus.occupancy_o), 1);
        tick();
        chk("t5_iv0", 64'(bus.issue_valid_o), 0);
        wake(1'b1, 6'd44, 1'b0, 6'd0);
        tick();
        idle();
        tick();
        chk("t5_iv_w",  64'(bus.issue_valid_o), 1);
        chk("t5_rob_w", 64'(bus.issue_rob_o), 51);
        chk("t5_occ_w", 64'(bus.occupancy_o), 0);
        tick();

        // Flush with one issue in flight and a concurrent dispatch
        for (int i = 0; i < 5; i++) begin
            disp(1'b1, 6'd55, 1'b0, 6'(20 + i));
            tick();
        end
        idle();
        wake(1'b1, 6'd55, 1'b0, 6'd0);
        tick();
        idle();
        tick();
        chk("t6_iv",  64'(bus.issue_valid_o), 1);
        chk("t6_rob", 64'(bus.issue_rob_o), 20);
        chk("t6_occ", 64'(bus.occupancy_o), 4);
        bus.flush_i = 1'b1;
        disp(1'b1, 6'd0, 1'b1, 6'd60);
        tick();
        idle();
        chk("t6_fl_occ", 64'(bus.occupancy_o), 0);
        chk("t6_fl_iv",  64'(bus.issue_valid_o), 0);
        tick();
        chk("t6_lost_iv",  64'(bus.issue_valid_o), 0);
        chk("t6_lost_occ", 64'(bus.occupancy_o), 0);

        // Asynchronous reset between edges
        disp(1'b1, 6'd0, 1'b1, 6'd30); tick();
        disp(1'b1, 6'd0, 1'b1, 6'd31); tick();
        idle();
        chk("t7_iv",  64'(bus.issue_valid_o), 1);
        chk("t7_occ", 64'(bus.occupancy_o), 1);
        #1 rst = 1'b1;
        #1;
        chk("t7_ar_occ",   64'(bus.occupancy_o), 0);
        chk("t7_ar_iv",    64'(bus.issue_valid_o), 0);
        chk("t7_ar_rob",   64'(bus.issue_rob_o), 0);
        chk("t7_ar_ready", 64'(bus.dispatch_ready_o), 1);
        #1 rst = 1'b0;
        tick();
        chk("t7_post_iv",  64'(bus.issue_valid_o), 0);
        chk("t7_post_occ", 64'(bus.occupancy_o), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
